fwft_queue: RTL
===============

# fwft_queue

Read-side counterpart to the team's synchronous-read `ram`/`queue` storage. It wraps a `ram` instance and hides the RAM's one-cycle read latency. Consumers see a first-word-fall-through valid/ready stream at full throughput. It sits between the labelling stage (producer) and downstream consumers that cannot tolerate registered-read timing.

## Interface
- `ADDR_WIDTH`, 8, RAM address width; RAM depth `DEPTH = 1 << ADDR_WIDTH`.
- `DATA_WIDTH`, 32, payload width.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_ready`  out  1  block accepts a word this cycle; reset 1.
- `in_data`  in  DATA_WIDTH  write payload.
- `out_valid`  out  1  `out_data` holds the oldest word; reset 0.
- `out_ready`  in  1  consumer takes `out_data` this cycle.
- `out_data`  out  DATA_WIDTH  oldest word, registered; reset 0.
- `count`  out  ADDR_WIDTH+2  total words held (RAM + in-flight + output stage); reset 0.

## Operation
- Push: `push = in_valid & in_ready`. On push, write `in_data` to `ram[wr_ptr]` and advance `wr_ptr`; it wraps modulo DEPTH.
- `in_ready = (ram_count < DEPTH)`. It is computed from registered state only, with no same-cycle bypass from reads. When the RAM is full, `in_ready` stays 0 even if a read issues that cycle.
- Pop: `pop = out_valid & out_ready`. It removes the head of the output stage.
- Output stage: two registers, head and skid, with occupancy `stage_occ` in 0..2. `inflight` is 1 when a RAM read was issued last cycle.
- Read issue: `issue = (ram_count > 0) & (stage_occ + inflight - pop < 2)`.
  - On issue, drive `r_addr = rd_ptr`, advance `rd_ptr` (wraps) and decrement `ram_count`.
- Returning RAM data goes to head if head is empty or being popped, else to skid. On pop with skid occupied, skid moves to head.
- `ram_count` changes by +push, −issue; simultaneous push and issue leave it unchanged.
- `count = ram_count + inflight + stage_occ`; its maximum is DEPTH+2.
- Ordering is strict FIFO. No word is dropped or duplicated.
- A push while `in_ready = 0` is ignored, with no state change.
- `out_data` is stable while `out_valid & ~out_ready`.
- Read-during-write: a read only targets entries written in an earlier cycle, so RAM old/new-data ambiguity never arises.
- Reset asserted at any time, including mid-burst:
  - Pointers, `ram_count`, `inflight` and `stage_occ` clear immediately. `out_valid` falls to 0 and `in_ready` goes to 1.
  - RAM contents are not cleared; they are unreachable after reset.
- Operation resumes on the first rising edge after reset deasserts.

## Timing
- Latency: a word pushed into an empty block in cycle N is presented with `out_valid = 1` in cycle N+3.
  - N: write.
  - N+1: read issue.
  - N+2: RAM `data_out`.
  - N+3: stage register.
- Throughput: one word per cycle sustained with `in_valid` and `out_ready` both held high.
- `count` updates one edge after the causing push or pop. `in_ready` deasserts the cycle after the RAM reaches DEPTH entries.
- Back-pressure: with `out_ready = 0`, at most two words leave the RAM (skid plus head). Remaining words stay in the RAM.

## Structure
- Sub-module: one instance of the existing `ram` (`ADDR_WIDTH`, `DATA_WIDTH` passed through; `wen = push`).
- No new shared typedefs or constants. `DEPTH` and the count width are local parameters derived from `ADDR_WIDTH`. Nothing is added to `global.vh`.
- Pointer, counter and stage logic sits in a single always block with an asynchronous reset branch.

## Test plan
- Reset then single push of 0xA5A5_0001 at cycle 0, `out_ready = 1`: `out_valid` rises at cycle 3 with `out_data = 0xA5A5_0001`. `count` goes 1 → 0 after the pop.
- Streaming: push 0..999 back-to-back with `out_ready = 1`: outputs 0..999 in order on consecutive cycles after the 3-cycle fill. `in_ready` never drops.
- Fill with ADDR_WIDTH=3 and `out_ready = 0`: `count` reaches 10 (8 in RAM + 2 in stage) and `in_ready = 0`. A push of 0xDEAD with `in_ready = 0` is not stored; draining yields exactly the 10 accepted words in order.
- Pointer wrap: ADDR_WIDTH=2, 50 random push/pop patterns with random `out_ready` gaps: output sequence equals the input sequence. `out_data` is stable on every stalled cycle.
- Full boundary: at full with simultaneous pop: `in_ready` stays 0 that cycle and returns to 1 the next cycle. `count` decrements by 1.
- Async reset mid-stream with 5 words held: `out_valid = 0`, `count = 0` and `in_ready = 1` before the next clock edge. A new push of 0x1234 appears 3 cycles later with no stale data.

Source files
------------

// File: rtl/fwft_queue_pkg.sv
// Shared helpers for the first-word-fall-through read wrapper around the
// synchronous-read ram.
package fwft_queue_pkg;

   // A new RAM read may only be issued when the two-entry output stage can
   // still hold every word that is already committed to it.
   function automatic logic canIssue(
      input logic [1:0] stageOcc,
      input logic       inflight,
      input logic       pop
   );
      logic [2:0] pending;
      pending = {1'b0, stageOcc} + {2'b00, inflight} - {2'b00, pop};
      return (pending < 3'd2);
   endfunction

endpackage

// File: rtl/ram.sv
// Simple dual-port RAM with a registered (one-cycle latency) read port.
module ram #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  wen,
   input  logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic [ADDR_WIDTH-1:0] r_addr,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

   // The read is registered every cycle. The caller decides whether the
   // returned word is meaningful.
   always_ff @(posedge clk) begin
      if (wen) begin
         mem[w_addr] <= w_data;
      end
      data_out <= mem[r_addr];
   end

endmodule

// File: rtl/fwft_queue.sv
// First-word-fall-through queue: it hides the ram read latency behind a
// two-entry (head + skid) output stage so consumers see a valid/ready stream.
module fwft_queue
   import fwft_queue_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH+1:0] count
);

   localparam int DEPTH       = 1 << ADDR_WIDTH;
   localparam int COUNT_WIDTH = ADDR_WIDTH + 2;
   localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PTR_STEP   = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] wrPtr;
   logic [ADDR_WIDTH-1:0] rdPtr;
   logic [ADDR_WIDTH:0]   ramCount;
   logic                  inflight;
   logic [1:0]            stageOcc;
   logic [1:0]            occAfterPop;
   logic [DATA_WIDTH-1:0] headData;
   logic [DATA_WIDTH-1:0] skidData;
   logic [DATA_WIDTH-1:0] ramData;
   logic                  push;
   logic                  pop;
   logic                  issue;

   // in_ready looks only at registered RAM occupancy. A read issued in the
   // same cycle does not free a slot until the next edge.
   assign in_ready    = (ramCount < FULL_LEVEL);
   assign out_valid   = (stageOcc != 2'd0);
   assign out_data    = headData;
   assign push        = in_valid & in_ready;
   assign pop         = out_valid & out_ready;
   assign issue       = (ramCount != '0) & canIssue(stageOcc, inflight, pop);
   assign occAfterPop = stageOcc - {1'b0, pop};
   assign count       = COUNT_WIDTH'(ramCount) + COUNT_WIDTH'(inflight)
                      + COUNT_WIDTH'(stageOcc);

   ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) storage (
      .clk      (clk),
      .wen      (push),
      .w_addr   (wrPtr),
      .w_data   (in_data),
      .r_addr   (rdPtr),
      .data_out (ramData)
   );

   // Pointers, RAM occupancy and the head/skid stage.
   // A returning read lands in the first free slot once this cycle's pop is
   // taken into account. The skid slides into head when head is consumed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         ramCount <= '0;
         inflight <= 1'b0;
         stageOcc <= '0;
         headData <= '0;
         skidData <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + PTR_STEP;
         end
         if (issue) begin
            rdPtr <= rdPtr + PTR_STEP;
         end
         ramCount <= ramCount + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
         inflight <= issue;

         if (pop && (stageOcc == 2'd2)) begin
            headData <= skidData;
         end
         if (inflight) begin
            if (occAfterPop == 2'd0) begin
               headData <= ramData;
            end else begin
               skidData <= ramData;
            end
         end
         stageOcc <= occAfterPop + {1'b0, inflight};
      end
   end

endmodule
